// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, mid-bit sampling, optional parity,
// one or two checked stop bits, one-cycle completion/error strobes and a held LED word.
module uart_rx_param #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [DATA_BITS-1:0] led
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

  state_t               state;
  logic                 sync_p0, rxs, rxs_p2;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_lat, frm_lat;
  logic                 half_hit, full_hit, fall;

  // Odd mode flags an even total of ones across data plus parity bit; even mode the reverse.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    return (PARITY == 1) ? ~x : x;
  endfunction

  assign half_hit = (baud_cnt == HALF_LAST);
  assign full_hit = (baud_cnt == FULL_LAST);
  assign fall     = rxs_p2 & ~rxs;

  // Stage p0/p1: synchroniser pair; stage p2: previous value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
      rxs_p2  <= 1'b1;
    end else begin
      sync_p0 <= rx_uart;
      rxs     <= sync_p0;
      rxs_p2  <= rxs;
    end
  end

  // Every frame overwrites all DATA_BITS positions before DONE reads them
  always_ff @(posedge clk) begin
    if (state == S_DATA && full_hit) shift <= {rxs, shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      par_lat    <= 1'b0;
      frm_lat    <= 1'b0;
      rx_data    <= '0;
      led        <= '0;
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_vld     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (fall) state <= S_START;
        end
        S_START: begin
          if (half_hit) begin
            baud_cnt <= '0;
            state    <= rxs ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          baud_cnt <= full_hit ? '0 : baud_cnt + 1'b1;
          if (full_hit) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          baud_cnt <= full_hit ? '0 : baud_cnt + 1'b1;
          if (full_hit) begin
            par_lat <= parity_bad(shift, rxs);
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          baud_cnt <= full_hit ? '0 : baud_cnt + 1'b1;
          if (full_hit) begin
            if (!rxs) frm_lat <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          rx_vld     <= 1'b1;
          rx_data    <= shift;
          parity_err <= par_lat;
          frame_err  <= frm_lat;
          if (!par_lat && !frm_lat) led <= shift;
          par_lat    <= 1'b0;
          frm_lat    <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations share clock and reset; each has its own line.
module tb_uart_rx_param;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rx_line;
  logic [7:0] d0, d1, d2, l0, l1, l2;
  logic [6:0] d3, l3;
  logic [3:0] vld, perr, ferr;
  logic [8:0] dat  [4];
  logic [8:0] ledv [4];
  logic [8:0] led_m [4];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct packed {
    logic [1:0]  inst;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic [31:0] cyc;
  } ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_line[0]), .rx_data(d0), .rx_vld(vld[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .led(l0));
  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_line[1]), .rx_data(d1), .rx_vld(vld[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .led(l1));
  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_line[2]), .rx_data(d2), .rx_vld(vld[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .led(l2));
  uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_line[3]), .rx_data(d3), .rx_vld(vld[3]),
    .parity_err(perr[3]), .frame_err(ferr[3]), .led(l3));

  assign dat[0]  = {1'b0, d0};
  assign dat[1]  = {1'b0, d1};
  assign dat[2]  = {1'b0, d2};
  assign dat[3]  = {2'b0, d3};
  assign ledv[0] = {1'b0, l0};
  assign ledv[1] = {1'b0, l1};
  assign ledv[2] = {1'b0, l2};
  assign ledv[3] = {2'b0, l3};

  // Log every completed frame, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (vld[k]) evq.push_back({2'(k), dat[k], perr[k], ferr[k], 32'(cyc)});
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1)
      for (int k = 0; k < 4; k++)
        if ((perr[k] | ferr[k]) && !vld[k]) begin
          failures++;
          $display("FAIL stray_strobe inst=%0d perr=%b ferr=%b vld=0, required: no error strobe without vld", k, perr[k], ferr[k]);
        end
  end

  function automatic int n_ev(input int k);
    int n = 0;
    foreach (evq[i]) if (evq[i].inst == 2'(k)) n++;
    return n;
  endfunction

  function automatic bit pop_ev(input int k, output ev_t e);
    e = '0;
    foreach (evq[i])
      if (evq[i].inst == 2'(k)) begin
        e = evq[i];
        evq.delete(i);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Odd mode wants an odd total of ones over data+parity, even mode an even total
  function automatic logic model_perr(input int mode, input int ones, input int pbit);
    int t = ones + pbit;
    return (mode == 1) ? (t % 2 == 0) : (t % 2 == 1);
  endfunction

  task automatic drive(input int k, input logic v);
    rx_line[k] = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int nbits);
    rx_line[k] = 1'b1;
    repeat (nbits * B) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [8:0] w, input int nb, input int pbit,
                            input logic [1:0] stops, input int nstop);
    drive(k, 1'b0);
    for (int i = 0; i < nb; i++) drive(k, w[i]);
    if (pbit >= 0) drive(k, pbit[0]);
    for (int i = 0; i < nstop; i++) drive(k, stops[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_line = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vld[k] !== 1'b0 || perr[k] !== 1'b0 || ferr[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_strobes inst=%0d got vld=%b perr=%b ferr=%b want 0", k, vld[k], perr[k], ferr[k]);
      end
      checks++;
      if (dat[k] !== 9'd0 || ledv[k] !== 9'd0) begin
        failures++;
        $display("FAIL reset_words inst=%0d got data=%h led=%h want 0", k, dat[k], ledv[k]);
      end
      led_m[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * B) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1();
    ev_t e;
    int c0;
    c0 = cyc;
    send_frame(0, 9'h031, 8, -1, 2'b11, 1);
    idle(0, 2);
    led_m[0] = 9'h031;
    checks++;
    if (n_ev(0) != 1) begin
      failures++;
      $display("FAIL 8n1_count got=%0d want=1", n_ev(0));
    end
    if (pop_ev(0, e)) begin
      checks++;
      if (e.data !== 9'h031) begin failures++; $display("FAIL 8n1_data got=%h want=031", e.data); end
      checks++;
      if (e.perr !== 1'b0 || e.ferr !== 1'b0) begin
        failures++;
        $display("FAIL 8n1_flags got perr=%b ferr=%b want 0 0", e.perr, e.ferr);
      end
      // Start mid at B/2, stop mid 9 bits later, 2 sync cycles, then DONE and its output cycle
      checks++;
      if (int'(e.cyc) != c0 + B / 2 + 9 * B + 4) begin
        failures++;
        $display("FAIL 8n1_latency got=%0d want=%0d", int'(e.cyc) - c0, B / 2 + 9 * B + 4);
      end
    end
    checks++;
    if (ledv[0] !== led_m[0]) begin failures++; $display("FAIL 8n1_led got=%h want=%h", ledv[0], led_m[0]); end
  endtask

  task automatic test_parity_even();
    ev_t e;
    for (int pb = 0; pb < 2; pb++) begin
      logic ep;
      ep = model_perr(2, $countones(9'h0A5), pb);
      send_frame(1, 9'h0A5, 8, pb, 2'b11, 1);
      idle(1, 1);
      if (!ep) led_m[1] = 9'h0A5;
      checks++;
      if (!pop_ev(1, e)) begin
        failures++;
        $display("FAIL even_parity_missing pbit=%0d got no rx_vld want one", pb);
      end else begin
        checks++;
        if (e.data !== 9'h0A5 || e.perr !== ep || e.ferr !== 1'b0) begin
          failures++;
          $display("FAIL even_parity pbit=%0d got data=%h perr=%b ferr=%b want 0a5 %b 0", pb, e.data, e.perr, e.ferr, ep);
        end
      end
      checks++;
      if (ledv[1] !== led_m[1]) begin failures++; $display("FAIL even_parity_led got=%h want=%h", ledv[1], led_m[1]); end
    end
  endtask

  task automatic test_stop2_break();
    ev_t e;
    send_frame(2, 9'h05A, 8, -1, 2'b01, 2);
    idle(2, 2);
    checks++;
    if (!pop_ev(2, e)) begin
      failures++;
      $display("FAIL stop2_missing got no rx_vld want one");
    end else begin
      checks++;
      if (e.data !== 9'h05A || e.ferr !== 1'b1 || e.perr !== 1'b0) begin
        failures++;
        $display("FAIL stop2 got data=%h ferr=%b perr=%b want 05a 1 0", e.data, e.ferr, e.perr);
      end
    end
    rx_line[2] = 1'b0;
    repeat (3 * 11 * B) @(posedge clk);
    #1;
    checks++;
    if (n_ev(2) != 1) begin failures++; $display("FAIL break_count got=%0d want=1", n_ev(2)); end
    if (pop_ev(2, e)) begin
      checks++;
      if (e.data !== 9'h000 || e.ferr !== 1'b1) begin
        failures++;
        $display("FAIL break_frame got data=%h ferr=%b want 000 1", e.data, e.ferr);
      end
    end
    idle(2, 4);
    checks++;
    if (n_ev(2) != 0) begin failures++; $display("FAIL break_after_rise got=%0d frames want=0", n_ev(2)); end
    checks++;
    if (ledv[2] !== led_m[2]) begin failures++; $display("FAIL stop2_led got=%h want=%h", ledv[2], led_m[2]); end
  endtask

  task automatic test_glitch_back_to_back();
    ev_t e;
    logic [8:0] exp_w [2];
    exp_w[0] = 9'h000;
    exp_w[1] = 9'h0FF;
    rx_line[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(0, 3);
    checks++;
    if (n_ev(0) != 0) begin failures++; $display("FAIL glitch got=%0d frames want=0", n_ev(0)); end
    send_frame(0, exp_w[0], 8, -1, 2'b11, 1);
    send_frame(0, exp_w[1], 8, -1, 2'b11, 1);
    idle(0, 2);
    led_m[0] = exp_w[1];
    checks++;
    if (n_ev(0) != 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", n_ev(0)); end
    for (int i = 0; i < 2; i++)
      if (pop_ev(0, e)) begin
        checks++;
        if (e.data !== exp_w[i] || e.ferr !== 1'b0) begin
          failures++;
          $display("FAIL b2b_frame%0d got data=%h ferr=%b want %h 0", i, e.data, e.ferr, exp_w[i]);
        end
      end
    checks++;
    if (ledv[0] !== led_m[0]) begin failures++; $display("FAIL b2b_led got=%h want=%h", ledv[0], led_m[0]); end
  endtask

  task automatic test_dbits7_odd();
    ev_t e;
    send_frame(3, 9'h041, 7, 1, 2'b11, 1);
    idle(3, 1);
    if (!model_perr(1, $countones(9'h041), 1)) led_m[3] = 9'h041;
    checks++;
    if (!pop_ev(3, e)) begin
      failures++;
      $display("FAIL d7_missing got no rx_vld want one");
    end else begin
      checks++;
      if (e.data !== 9'h041 || e.perr !== 1'b0 || e.ferr !== 1'b0) begin
        failures++;
        $display("FAIL d7_odd got data=%h perr=%b ferr=%b want 041 0 0", e.data, e.perr, e.ferr);
      end
    end
    checks++;
    if (ledv[3] !== led_m[3]) begin failures++; $display("FAIL d7_led got=%h want=%h", ledv[3], led_m[3]); end
  endtask

  task automatic test_random();
    ev_t e;
    int k, nb, mode, pbit, ones;
    logic [8:0] w;
    logic good_p, good_s, ep, ef;
    for (int n = 0; n < 24; n++) begin
      k      = (n % 2 == 0) ? 1 : 3;
      nb     = (k == 1) ? 8 : 7;
      mode   = (k == 1) ? 2 : 1;
      w      = 9'($urandom_range(0, (1 << nb) - 1));
      good_p = ($urandom_range(0, 3) != 0);
      good_s = ($urandom_range(0, 4) != 0);
      ones   = $countones(w);
      pbit   = (mode == 2) ? (ones % 2) : (1 - ones % 2);
      if (!good_p) pbit = 1 - pbit;
      ep = model_perr(mode, ones, pbit);
      ef = !good_s;
      send_frame(k, w, nb, pbit, {1'b1, good_s}, 1);
      idle(k, 1 + $urandom_range(0, 2));
      if (!ep && !ef) led_m[k] = w;
      checks++;
      if (!pop_ev(k, e)) begin
        failures++;
        $display("FAIL rand%0d_missing inst=%0d got no rx_vld want one", n, k);
      end else begin
        checks++;
        if (e.data !== w || e.perr !== ep || e.ferr !== ef) begin
          failures++;
          $display("FAIL rand%0d inst=%0d got data=%h perr=%b ferr=%b want %h %b %b", n, k, e.data, e.perr, e.ferr, w, ep, ef);
        end
      end
      checks++;
      if (ledv[k] !== led_m[k]) begin failures++; $display("FAIL rand%0d_led got=%h want=%h", n, ledv[k], led_m[k]); end
    end
  endtask

  task automatic test_midframe_reset();
    ev_t e;
    logic [8:0] w;
    w = 9'h0C3;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, w[i]);
    rx_line[0] = w[4];
    repeat (B / 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) led_m[k] = '0;
    checks++;
    if (vld !== 4'b0 || dat[0] !== 9'd0 || ledv[0] !== 9'd0 || ledv[1] !== 9'd0) begin
      failures++;
      $display("FAIL midreset_outputs got vld=%b data=%h led0=%h led1=%h want all 0", vld, dat[0], ledv[0], ledv[1]);
    end
    rx_line = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(0, 2);
    checks++;
    if (n_ev(0) != 0) begin failures++; $display("FAIL midreset_strobe got=%0d frames want=0", n_ev(0)); end
    send_frame(0, 9'h03C, 8, -1, 2'b11, 1);
    idle(0, 1);
    led_m[0] = 9'h03C;
    checks++;
    if (!pop_ev(0, e)) begin
      failures++;
      $display("FAIL post_reset_missing got no rx_vld want one");
    end else begin
      checks++;
      if (e.data !== 9'h03C || e.perr !== 1'b0 || e.ferr !== 1'b0) begin
        failures++;
        $display("FAIL post_reset got data=%h perr=%b ferr=%b want 03c 0 0", e.data, e.perr, e.ferr);
      end
    end
    checks++;
    if (ledv[0] !== led_m[0]) begin failures++; $display("FAIL post_reset_led got=%h want=%h", ledv[0], led_m[0]); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_even();
    test_stop2_break();
    test_glitch_back_to_back();
    test_dbits7_odd();
    test_random();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end
endmodule
